// File: rtl/downsize_fifo_pkg.sv
// Shared constants and helpers for the width-downsizing FIFO.
// Holds the default geometry and the derived sub-word / sub-index widths
// so the top level and the storage array agree on their sizes.
package downsize_fifo_pkg;

  // Default input word width, sub-words per word and log2 of word depth
  localparam int DEFAULT_WIDTH      = 32;
  localparam int DEFAULT_RATIO      = 4;
  localparam int DEFAULT_DEPTH_LOG2 = 2;

  // Ceiling log2 usable in constant expressions
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Width of one output sub-word
  function automatic int subWidth(input int width, input int ratio);
    return width / ratio;
  endfunction

  // Width of the sub-index that walks through one stored word
  function automatic int subIdxWidth(input int ratio);
    return (clog2(ratio) < 1) ? 1 : clog2(ratio);
  endfunction

endpackage

// File: rtl/downsize_fifo_mem.sv
// Word storage for the downsizing FIFO: a flop-based register array with
// one synchronous write port and one asynchronous read port. The array is
// deliberately not reset; only the pointers around it carry reset state.
module downsize_fifo_mem
  import downsize_fifo_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] storage_q [DEPTH];

  // Capture the incoming word into the addressed slot on an accepted write
  always_ff @(posedge clk) begin
    if (we_i) begin
      storage_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = storage_q[raddr_i];

endmodule

// File: rtl/downsize_fifo.sv
// Width-downsizing show-ahead FIFO: accepts WIDTH-bit words and presents
// them as RATIO narrower sub-words, most-significant sub-word first.
// Defining DOWNSIZE_FIFO_LSB_FIRST_EN switches the sub-word order to
// least-significant first; nothing else changes.
// usedw counts whole words, including a head word that is partly read.
module downsize_fifo
  import downsize_fifo_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int RATIO      = DEFAULT_RATIO,
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                              clk,
  input  logic                              aclr_n,
  input  logic                              clear,
  input  logic                              wrreq,
  input  logic [WIDTH-1:0]                  data,
  output logic                              full,
  output logic [DEPTH_LOG2:0]               usedw,
  input  logic                              rdreq,
  output logic [subWidth(WIDTH, RATIO)-1:0] q,
  output logic                              empty
);

  localparam int SUB_W = subWidth(WIDTH, RATIO);
  localparam int IDX_W = subIdxWidth(RATIO);
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(RATIO - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
  logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
  logic [IDX_W-1:0]      subIdx_q, subIdx_d;
  logic [CNT_W-1:0]      usedw_q, usedw_d;

  logic             wrAccept;
  logic             rdAccept;
  logic             rdComplete;
  logic [WIDTH-1:0] headWord;
  logic [IDX_W-1:0] sliceSel;

  // Flags come straight from the registered word count, so a freshly
  // written word only becomes visible after the edge that stored it
  assign full  = (usedw_q == DEPTH_CNT);
  assign empty = (usedw_q == '0);
  assign usedw = usedw_q;

  // A flush wins over both requests; a full FIFO drops writes even when the
  // head word is finishing in the same cycle
  assign wrAccept   = wrreq & ~full & ~clear;
  assign rdAccept   = rdreq & ~empty & ~clear;
  assign rdComplete = rdAccept & (subIdx_q == LAST_IDX);

  downsize_fifo_mem #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .we_i    (wrAccept),
    .waddr_i (wrPtr_q),
    .wdata_i (data),
    .raddr_i (rdPtr_q),
    .rdata_o (headWord)
  );

  // Next-state for pointers, sub-index and word count
  always_comb begin
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    subIdx_d = subIdx_q;
    usedw_d  = usedw_q;

    if (clear) begin
      wrPtr_d  = '0;
      rdPtr_d  = '0;
      subIdx_d = '0;
      usedw_d  = '0;
    end else begin
      if (wrAccept) begin
        wrPtr_d = wrPtr_q + DEPTH_LOG2'(1);
      end
      if (rdAccept) begin
        subIdx_d = subIdx_q + IDX_W'(1);
      end
      if (rdComplete) begin
        subIdx_d = '0;
        rdPtr_d  = rdPtr_q + DEPTH_LOG2'(1);
      end
      if (wrAccept && !rdComplete) begin
        usedw_d = usedw_q + CNT_W'(1);
      end else if (rdComplete && !wrAccept) begin
        usedw_d = usedw_q - CNT_W'(1);
      end
    end
  end

  // Pointer and count registers; the asynchronous clear drops any partly
  // read word and restarts from empty
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      subIdx_q <= '0;
      usedw_q  <= '0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      subIdx_q <= subIdx_d;
      usedw_q  <= usedw_d;
    end
  end

  // Map the read sub-index to a physical slice position inside the head word
  always_comb begin
`ifdef DOWNSIZE_FIFO_LSB_FIRST_EN
    sliceSel = subIdx_q;
`else
    sliceSel = LAST_IDX - subIdx_q;
`endif
  end

  // Show-ahead output: the selected slice of the head word
  always_comb begin
    q = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (sliceSel == IDX_W'(i)) begin
        q = headWord[i*SUB_W +: SUB_W];
      end
    end
  end

endmodule

// File: tb/tb_downsize_fifo.sv
// Scoreboard bench for downsize_fifo: stimulus pushes expected sub-words as
// words are written, and a negedge monitor pops and compares them whenever
// the DUT accepts a read. A second instance covers the 64-bit / 8-way build.
module tb_downsize_fifo;

  logic clk = 1'b0;

  // Free-running 10 ns clock shared by both instances
  always #5 clk = ~clk;

  logic        aclr_n;
  logic        clear, wrreq, rdreq;
  logic [31:0] data;
  logic        full, empty;
  logic [2:0]  usedw;
  logic [7:0]  q;

  logic        clear2, wrreq2, rdreq2;
  logic [63:0] data2;
  logic        full2, empty2;
  logic [2:0]  usedw2;
  logic [7:0]  q2;

  int checks   = 0;
  int failures = 0;

  logic [7:0] expQ[$];
  logic [7:0] expQ2[$];

  downsize_fifo #(.WIDTH(32), .RATIO(4), .DEPTH_LOG2(2)) dut (
    .clk(clk), .aclr_n(aclr_n), .clear(clear), .wrreq(wrreq), .data(data),
    .full(full), .usedw(usedw), .rdreq(rdreq), .q(q), .empty(empty)
  );

  downsize_fifo #(.WIDTH(64), .RATIO(8), .DEPTH_LOG2(2)) dut2 (
    .clk(clk), .aclr_n(aclr_n), .clear(clear2), .wrreq(wrreq2), .data(data2),
    .full(full2), .usedw(usedw2), .rdreq(rdreq2), .q(q2), .empty(empty2)
  );

  // Compare one observed value against its expectation and tally the result
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Queue the sub-words of a 32-bit word in the order the DUT should emit them
  task automatic pushWord(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
`ifdef DOWNSIZE_FIFO_LSB_FIRST_EN
      expQ.push_back(w[8*i +: 8]);
`else
      expQ.push_back(w[31-8*i -: 8]);
`endif
    end
  endtask

  // Queue the sub-words of a 64-bit word for the wide instance
  task automatic pushWord2(input logic [63:0] w);
    for (int i = 0; i < 8; i++) begin
`ifdef DOWNSIZE_FIFO_LSB_FIRST_EN
      expQ2.push_back(w[8*i +: 8]);
`else
      expQ2.push_back(w[63-8*i -: 8]);
`endif
    end
  endtask

  // Drive one cycle of requests on the 32-bit instance, then return to idle
  task automatic applyStimulus(input logic wr, input logic [31:0] d, input logic rd,
                               input logic clr, input logic expectAccept);
    wrreq = wr;
    data  = d;
    rdreq = rd;
    clear = clr;
    if (wr && expectAccept) pushWord(d);
    @(posedge clk);
    #1;
    wrreq = 1'b0;
    rdreq = 1'b0;
    clear = 1'b0;
  endtask

  // Drive one cycle of requests on the 64-bit instance, then return to idle
  task automatic applyStimulus2(input logic wr, input logic [63:0] d, input logic rd);
    wrreq2 = wr;
    data2  = d;
    rdreq2 = rd;
    if (wr) pushWord2(d);
    @(posedge clk);
    #1;
    wrreq2 = 1'b0;
    rdreq2 = 1'b0;
  endtask

  // Distinct byte pattern per word for the streaming wrap-around run
  function automatic logic [31:0] wrapWord(input int k);
    logic [7:0] b;
    b = 8'(k);
    return {b, b + 8'h40, b + 8'h80, b + 8'hC0};
  endfunction

  // Monitor: every accepted read must present the next queued sub-word
  always @(negedge clk) begin
    if (aclr_n && rdreq && !empty && !clear) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL q_unexpected: got 0x%0h expected no data", q);
      end else begin
        checkOutput("q", q, expQ.pop_front());
      end
    end
    if (aclr_n && rdreq2 && !empty2 && !clear2) begin
      if (expQ2.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL q2_unexpected: got 0x%0h expected no data", q2);
      end else begin
        checkOutput("q2", q2, expQ2.pop_front());
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    aclr_n = 1'b1;
    clear = 1'b0; wrreq = 1'b0; rdreq = 1'b0; data = '0;
    clear2 = 1'b0; wrreq2 = 1'b0; rdreq2 = 1'b0; data2 = '0;
    #2 aclr_n = 1'b0;
    #10;
    checkOutput("reset_empty", empty, 1);
    checkOutput("reset_full", full, 0);
    checkOutput("reset_usedw", usedw, 0);
    checkOutput("reset_empty2", empty2, 1);
    aclr_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic order");
    applyStimulus(1, 32'h11223344, 0, 0, 1);
    checkOutput("basic_empty", empty, 0);
    checkOutput("basic_usedw", usedw, 1);
    repeat (4) applyStimulus(0, '0, 1, 0, 1);
    checkOutput("basic_drained_empty", empty, 1);
    checkOutput("basic_drained_usedw", usedw, 0);

    $display("[TB] fill and overflow");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 32'hA0000000 + 32'(i), 0, 0, i < 4);
      if (i == 2) checkOutput("fill_not_full", full, 0);
      if (i == 3) checkOutput("fill_full", full, 1);
    end
    checkOutput("overflow_usedw", usedw, 4);
    checkOutput("overflow_full", full, 1);
    repeat (16) applyStimulus(0, '0, 1, 0, 1);
    checkOutput("fill_drained_empty", empty, 1);

    $display("[TB] simultaneous events");
    applyStimulus(1, 32'hB0000001, 0, 0, 1);
    applyStimulus(1, 32'hB0000002, 0, 0, 1);
    repeat (3) applyStimulus(0, '0, 1, 0, 1);
    checkOutput("simul_before_usedw", usedw, 2);
    applyStimulus(1, 32'hB0000003, 1, 0, 1);
    checkOutput("simul_after_usedw", usedw, 2);
    repeat (8) applyStimulus(0, '0, 1, 0, 1);
    checkOutput("simul_drained_empty", empty, 1);
    repeat (2) applyStimulus(0, '0, 1, 0, 1);
    checkOutput("underflow_usedw", usedw, 0);
    checkOutput("underflow_empty", empty, 1);
    applyStimulus(1, 32'hB0000004, 0, 0, 1);
    checkOutput("after_underflow_usedw", usedw, 1);
    repeat (4) applyStimulus(0, '0, 1, 0, 1);

    $display("[TB] completing read while full");
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'hC0000000 + 32'(i), 0, 0, 1);
    repeat (3) applyStimulus(0, '0, 1, 0, 1);
    checkOutput("fullread_full", full, 1);
    applyStimulus(1, 32'hC0000004, 1, 0, 0);
    checkOutput("fullread_usedw", usedw, 3);
    checkOutput("fullread_not_full", full, 0);
    repeat (12) applyStimulus(0, '0, 1, 0, 1);
    checkOutput("fullread_drained_empty", empty, 1);

    $display("[TB] wrap-around stream");
    applyStimulus(1, wrapWord(0), 0, 0, 1);
    for (int k = 0; k < 12; k++) begin
      for (int s = 0; s < 4; s++) begin
        applyStimulus((s == 0) && (k < 11), wrapWord(k + 1), 1, 0, 1);
      end
    end
    checkOutput("wrap_usedw", usedw, 0);
    checkOutput("wrap_empty", empty, 1);

    $display("[TB] async reset mid-word");
    applyStimulus(1, 32'hD1D2D3D4, 0, 0, 1);
    repeat (2) applyStimulus(0, '0, 1, 0, 1);
    #2 aclr_n = 1'b0;
    #1;
    checkOutput("areset_empty", empty, 1);
    checkOutput("areset_usedw", usedw, 0);
    checkOutput("areset_full", full, 0);
    expQ.delete();
    #1 aclr_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1, 32'hE1E2E3E4, 0, 0, 1);
    repeat (4) applyStimulus(0, '0, 1, 0, 1);
    checkOutput("areset_resume_empty", empty, 1);

    $display("[TB] clear mid-word");
    applyStimulus(1, 32'hF1F2F3F4, 0, 0, 1);
    repeat (2) applyStimulus(0, '0, 1, 0, 1);
    applyStimulus(1, 32'h99999999, 1, 1, 0);
    expQ.delete();
    checkOutput("clear_empty", empty, 1);
    checkOutput("clear_usedw", usedw, 0);
    applyStimulus(1, 32'h5A6B7C8D, 0, 0, 1);
    repeat (4) applyStimulus(0, '0, 1, 0, 1);
    checkOutput("clear_resume_empty", empty, 1);

    $display("[TB] 64-bit by 8 counting pattern");
    applyStimulus2(1, 64'h0001020304050607, 0);
    applyStimulus2(1, 64'h08090A0B0C0D0E0F, 0);
    checkOutput("wide_usedw", usedw2, 2);
    repeat (16) applyStimulus2(0, '0, 1);
    checkOutput("wide_drained_empty", empty2, 1);

    checkOutput("queues_drained", 64'(expQ.size() + expQ2.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/downsize_fifo.md
DOWNSIZE_FIFO -- requirements
Module: downsize_fifo

Interface
REQ-001 Parameter WIDTH, default 32, meaning input word width in bits.
REQ-002 Parameter RATIO, default 4, meaning output sub-words per input word; power of two, >=2; WIDTH divisible by RATIO.
REQ-003 Parameter DEPTH_LOG2, default 2, meaning storage depth is 2**DEPTH_LOG2 words.
REQ-004 Port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 Port aclr_n, input, 1, meaning asynchronous active-low reset.
REQ-006 Port clear, input, 1, meaning synchronous flush.
REQ-007 Port wrreq, input, 1, meaning write one WIDTH-bit word.
REQ-008 Port data, input, WIDTH, meaning the write word.
REQ-009 Port full, output, 1, meaning no free word slot.
REQ-010 Port usedw, output, DEPTH_LOG2+1, meaning count of words held, including a partially read head word.
REQ-011 Port rdreq, input, 1, meaning consume the current sub-word.
REQ-012 Port q, output, WIDTH/RATIO, meaning current head sub-word, show-ahead.
REQ-013 Port empty, output, 1, meaning no sub-word available.

Function
REQ-014 Write is accepted iff wrreq=1, full=0 and clear=0; data goes into the slot at wrptr, and wrptr increments modulo 2**DEPTH_LOG2.
REQ-015 A write while full=1 is dropped, and no state changes.
REQ-016 A read is accepted iff rdreq=1, empty=0 and clear=0; the sub-index increments modulo RATIO.
REQ-017 On the accepted read of sub-index RATIO-1, the sub-index wraps to 0 and rdptr increments modulo depth.
REQ-018 A read while empty=1 is ignored; q is undefined but pointers and the count do not move (underflow protection).
REQ-019 q = slice of storage[rdptr] selected by the sub-index, purely combinational from registered state.
REQ-020 Default slice order is most-significant first: sub-index 0 selects data[WIDTH-1 -: WIDTH/RATIO].
REQ-021 usedw increments on an accepted write without a word-completing read.
REQ-022 usedw decrements on a word-completing read without an accepted write.
REQ-023 usedw is unchanged when both or neither occur; usedw never exceeds 2**DEPTH_LOG2.
REQ-024 full = (usedw == 2**DEPTH_LOG2) and empty = (usedw == 0), both derived from registered state.
REQ-025 Latency: a word written at edge N gives empty=0 and a valid q in the cycle after edge N; there is no write-to-read bypass while empty.
REQ-026 On a simultaneous accepted write and word-completing read when full=0, both take effect and usedw is unchanged.
REQ-027 When full=1, a write in the same cycle as a completing read is still dropped.
REQ-028 clear=1 at a clock edge zeroes wrptr, rdptr, sub-index and usedw, and overrides wrreq and rdreq; storage contents are not cleared.

Reset
REQ-029 When aclr_n=0, wrptr, rdptr, sub-index and usedw go to 0 immediately, independent of clk; hence empty=1 and full=0.
REQ-030 Storage is not reset, so q is undefined while empty.
REQ-031 Deassertion of aclr_n mid-operation resumes from the empty state, and any partially read word is lost.

Configuration
REQ-032 Macro DOWNSIZE_FIFO_LSB_FIRST_EN: when defined, sub-index 0 selects data[WIDTH/RATIO-1:0], with ascending significance.
REQ-033 When DOWNSIZE_FIFO_LSB_FIRST_EN is undefined, the most-significant-first order of REQ-020 applies; no other behaviour differs.

Structure
REQ-034 Shared package downsize_fifo_pkg SHALL hold the clog2 function, the default WIDTH, RATIO and DEPTH_LOG2 constants, and the derived sub-word-width and sub-index-width expressions.
REQ-035 Sub-module downsize_fifo_mem SHALL implement the 2**DEPTH_LOG2 x WIDTH register array.
REQ-036 downsize_fifo_mem SHALL have one synchronous write port, one asynchronous read port, no reset, and a logic (non-block-RAM) implementation.
REQ-037 Pointers, sub-index, counter and flag logic SHALL live in downsize_fifo.

Verification
REQ-038 Basic order, defaults: reset, write 0x11223344 -> next cycle empty=0, usedw=1; four reads return q=0x11,0x22,0x33,0x44; then empty=1, usedw=0.
REQ-039 Fill and overflow: write 5 words 0xA0000000..0xA0000004 back-to-back -> full=1 after the 4th write; the 5th is dropped; 16 reads return bytes of words 0..3 only.
REQ-040 Simultaneous events: with usedw=2 and sub-index=3, rdreq and wrreq in the same cycle -> usedw stays 2 and rdptr advances; read with empty=1 -> usedw stays 0 and pointers are unchanged.
REQ-041 Wrap-around: write and read 12 words continuously -> every byte is in order, and pointers wrap three times without error.
REQ-042 Reset/clear mid-word: after 2 of 4 byte reads, pulse aclr_n low asynchronously between edges -> empty=1 and usedw=0 at once; repeat with clear=1 -> same result at the next edge.
REQ-043 Macro build with DOWNSIZE_FIFO_LSB_FIRST_EN defined: write 0x11223344 -> reads return 0x44,0x33,0x22,0x11; also run WIDTH=64, RATIO=8 with a counting pattern.
